// File: rtl/play_judge.sv
// play_judge: multi-lane rhythm-judging core. Fetches chart notes, lights the target lane,
// grades hits (perfect/good/miss) and keeps a saturating score and combo.
// Optional autoplay input is enabled by defining PLAY_JUDGE_AUTOPLAY_EN.
module play_judge #(
    parameter int NUM_LANES   = 7,
    parameter int LANE_W      = 3,
    parameter int CLOCK_W     = 24,
    parameter int CNT_W       = 8,
    parameter int SCORE_W     = 21,
    parameter int COMBO_W     = 12,
    parameter int PERFECT_WIN = 4,
    parameter int GOOD_WIN    = 12,
    parameter int PERFECT_PTS = 300,
    parameter int GOOD_PTS    = 100,
    parameter int BONUS_CAP   = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 hit,
    input  logic [LANE_W-1:0]    hit_lane,
    input  logic [CLOCK_W-1:0]   now,
    output logic                 note_req,
    output logic [CNT_W-1:0]     note_idx,
    input  logic                 note_valid,
    input  logic [LANE_W-1:0]    note_lane,
    input  logic [CLOCK_W-1:0]   note_time,
    input  logic                 note_last,
`ifdef PLAY_JUDGE_AUTOPLAY_EN
    input  logic                 autoplay,
`endif
    output logic [NUM_LANES-1:0] target_led,
    output logic                 judge_valid,
    output logic [1:0]           judge_grade,
    output logic [SCORE_W-1:0]   score,
    output logic [COMBO_W-1:0]   combo,
    output logic [COMBO_W-1:0]   max_combo,
    output logic                 done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_JUDGE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [1:0] GRADE_MISS    = 2'd0;
    localparam logic [1:0] GRADE_GOOD    = 2'd1;
    localparam logic [1:0] GRADE_PERFECT = 2'd2;

    localparam int SUM_W = SCORE_W + 2;

    localparam logic signed [CLOCK_W-1:0] GOOD_S     = CLOCK_W'(GOOD_WIN);
    localparam logic signed [CLOCK_W-1:0] NEG_GOOD_S = CLOCK_W'(-GOOD_WIN);
    localparam logic signed [CLOCK_W-1:0] PERF_S     = CLOCK_W'(PERFECT_WIN);
    localparam logic signed [CLOCK_W-1:0] NEG_PERF_S = CLOCK_W'(-PERFECT_WIN);

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [COMBO_W-1:0] BONUS_MAX = COMBO_W'(BONUS_CAP);

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        logic [NUM_LANES-1:0] led;
        for (int i = 0; i < NUM_LANES; i++) begin
            led[i] = (lane == LANE_W'(i));
        end
        return led;
    endfunction

    state_t               state_r, state_s;
    logic                 en_q_r;
    logic [CNT_W-1:0]     note_idx_r, note_idx_s;
    logic [LANE_W-1:0]    lane_r, lane_s;
    logic [CLOCK_W-1:0]   time_r, time_s;
    logic                 last_r, last_s;
    logic                 note_req_r, note_req_s;
    logic [NUM_LANES-1:0] target_led_r, target_led_s;
    logic                 judge_valid_r, judge_valid_s;
    logic [1:0]           judge_grade_r, judge_grade_s;
    logic [SCORE_W-1:0]   score_r, score_s;
    logic [COMBO_W-1:0]   combo_r, combo_s;
    logic [COMBO_W-1:0]   max_combo_r, max_combo_s;
    logic                 done_r, done_s;

    logic signed [CLOCK_W-1:0] delta_s;
    logic                      early_s;
    logic                      late_s;
    logic                      perfect_s;
    logic                      player_decide_s;
    logic [1:0]                player_grade_s;
    logic                      decide_s;
    logic [1:0]                grade_s;
    logic [COMBO_W-1:0]        bonus_s;
    logic [SUM_W-1:0]          pts_s;
    logic [SUM_W-1:0]          sum_s;
    logic [SCORE_W-1:0]        score_add_s;
    logic [COMBO_W-1:0]        combo_inc_s;

    // Modular difference reinterpreted as signed so the window test survives tick wrap.
    assign delta_s   = $signed(now - time_r);
    assign early_s   = (delta_s < NEG_GOOD_S);
    assign late_s    = (delta_s > GOOD_S);
    assign perfect_s = (delta_s >= NEG_PERF_S) && (delta_s <= PERF_S);

    // Player-driven grading decision for the current WAIT cycle.
    always_comb begin
        player_decide_s = 1'b0;
        player_grade_s  = GRADE_MISS;
        if (hit && early_s) begin
            player_decide_s = 1'b0;
        end else if (hit && !late_s && (hit_lane == lane_r)) begin
            player_decide_s = 1'b1;
            player_grade_s  = perfect_s ? GRADE_PERFECT : GRADE_GOOD;
        end else if (hit) begin
            player_decide_s = 1'b1;
            player_grade_s  = GRADE_MISS;
        end else if (late_s) begin
            player_decide_s = 1'b1;
            player_grade_s  = GRADE_MISS;
        end else begin
            player_decide_s = 1'b0;
        end
    end

    // Selects between autoplay and player grading.
    always_comb begin
        decide_s = player_decide_s;
        grade_s  = player_grade_s;
`ifdef PLAY_JUDGE_AUTOPLAY_EN
        if (autoplay) begin
            decide_s = !delta_s[CLOCK_W-1];
            grade_s  = GRADE_PERFECT;
        end else begin
            decide_s = player_decide_s;
            grade_s  = player_grade_s;
        end
`endif
    end

    // Saturating score and combo arithmetic for a successful hit.
    always_comb begin
        bonus_s = (combo_r < BONUS_MAX) ? combo_r : BONUS_MAX;
        if (grade_s == GRADE_PERFECT) begin
            pts_s = SUM_W'(PERFECT_PTS);
        end else begin
            pts_s = SUM_W'(GOOD_PTS);
        end
        sum_s = SUM_W'(score_r) + pts_s + SUM_W'(bonus_s);
        if (sum_s[SUM_W-1:SCORE_W] != 2'b00) begin
            score_add_s = SCORE_MAX;
        end else begin
            score_add_s = sum_s[SCORE_W-1:0];
        end
        if (&combo_r) begin
            combo_inc_s = combo_r;
        end else begin
            combo_inc_s = combo_r + COMBO_W'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s       = state_r;
        note_idx_s    = note_idx_r;
        lane_s        = lane_r;
        time_s        = time_r;
        last_s        = last_r;
        note_req_s    = 1'b0;
        target_led_s  = {NUM_LANES{1'b0}};
        judge_valid_s = 1'b0;
        judge_grade_s = judge_grade_r;
        score_s       = score_r;
        combo_s       = combo_r;
        max_combo_s   = max_combo_r;
        done_s        = done_r;

        case (state_r)
            ST_IDLE: begin
                if (en && !en_q_r) begin
                    state_s     = ST_FETCH;
                    note_req_s  = 1'b1;
                    note_idx_s  = {CNT_W{1'b0}};
                    score_s     = {SCORE_W{1'b0}};
                    combo_s     = {COMBO_W{1'b0}};
                    max_combo_s = {COMBO_W{1'b0}};
                    done_s      = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!en) begin
                    state_s = ST_IDLE;
                end else if (note_valid) begin
                    state_s      = ST_WAIT;
                    lane_s       = note_lane;
                    time_s       = note_time;
                    last_s       = note_last;
                    target_led_s = lane_onehot(note_lane);
                end else begin
                    note_req_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!en) begin
                    state_s = ST_IDLE;
                end else if (decide_s) begin
                    state_s       = ST_JUDGE;
                    judge_valid_s = 1'b1;
                    judge_grade_s = grade_s;
                    if (grade_s == GRADE_MISS) begin
                        combo_s = {COMBO_W{1'b0}};
                    end else begin
                        score_s = score_add_s;
                        combo_s = combo_inc_s;
                        if (combo_inc_s > max_combo_r) begin
                            max_combo_s = combo_inc_s;
                        end else begin
                            max_combo_s = max_combo_r;
                        end
                    end
                end else begin
                    target_led_s = lane_onehot(lane_r);
                end
            end
            ST_JUDGE: begin
                if (!en) begin
                    state_s = ST_IDLE;
                end else if (last_r) begin
                    state_s = ST_FIN;
                    done_s  = 1'b1;
                end else begin
                    state_s    = ST_FETCH;
                    note_idx_s = note_idx_r + CNT_W'(1);
                    note_req_s = 1'b1;
                end
            end
            ST_FIN: begin
                if (!en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            en_q_r        <= 1'b0;
            note_idx_r    <= {CNT_W{1'b0}};
            lane_r        <= {LANE_W{1'b0}};
            time_r        <= {CLOCK_W{1'b0}};
            last_r        <= 1'b0;
            note_req_r    <= 1'b0;
            target_led_r  <= {NUM_LANES{1'b0}};
            judge_valid_r <= 1'b0;
            judge_grade_r <= GRADE_MISS;
            score_r       <= {SCORE_W{1'b0}};
            combo_r       <= {COMBO_W{1'b0}};
            max_combo_r   <= {COMBO_W{1'b0}};
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            en_q_r        <= en;
            note_idx_r    <= note_idx_s;
            lane_r        <= lane_s;
            time_r        <= time_s;
            last_r        <= last_s;
            note_req_r    <= note_req_s;
            target_led_r  <= target_led_s;
            judge_valid_r <= judge_valid_s;
            judge_grade_r <= judge_grade_s;
            score_r       <= score_s;
            combo_r       <= combo_s;
            max_combo_r   <= max_combo_s;
            done_r        <= done_s;
        end
    end

    assign note_req    = note_req_r;
    assign note_idx    = note_idx_r;
    assign target_led  = target_led_r;
    assign judge_valid = judge_valid_r;
    assign judge_grade = judge_grade_r;
    assign score       = score_r;
    assign combo       = combo_r;
    assign max_combo   = max_combo_r;
    assign done        = done_r;

endmodule

// File: tb/tb_play_judge.sv
// Self-checking bench for play_judge: a table of directed notes plus hand-written
// sequences for finish, tick wrap, abort, score/combo saturation and reset.
module tb_play_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        hit = 1'b0;
    logic [2:0]  hit_lane = 3'd0;
    logic [23:0] now = 24'd0;
    logic        note_req;
    logic [7:0]  note_idx;
    logic        note_valid = 1'b0;
    logic [2:0]  note_lane = 3'd0;
    logic [23:0] note_time = 24'd0;
    logic        note_last = 1'b0;
    logic [6:0]  target_led;
    logic        judge_valid;
    logic [1:0]  judge_grade;
    logic [20:0] score;
    logic [11:0] combo;
    logic [11:0] max_combo;
    logic        done;

    int passed = 0;
    int total = 0;

    play_judge dut (
        .clk(clk), .rst(rst), .en(en), .hit(hit), .hit_lane(hit_lane), .now(now),
        .note_req(note_req), .note_idx(note_idx), .note_valid(note_valid),
        .note_lane(note_lane), .note_time(note_time), .note_last(note_last),
`ifdef PLAY_JUDGE_AUTOPLAY_EN
        .autoplay(1'b0),
`endif
        .target_led(target_led), .judge_valid(judge_valid), .judge_grade(judge_grade),
        .score(score), .combo(combo), .max_combo(max_combo), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  lane;
        logic [23:0] ntime;
        logic        last;
        logic        pre_hit;
        logic [23:0] pre_now;
        logic        do_hit;
        logic [23:0] hit_now;
        logic [2:0]  hlane;
        logic [1:0]  grade;
        int          sc;
        int          cb;
        int          mx;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Waits (bounded) for a request, answers it and checks the lit lane.
    task automatic fetch(input logic [2:0] l, input logic [23:0] t, input logic lst,
                         input int idx, input bit verbose);
        int n = 0;
        while (note_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (verbose || note_req !== 1'b1) chk("note_req_raised", 32'(note_req), 32'd1);
        if (verbose) chk("note_idx", 32'(note_idx), 32'(idx));
        note_valid = 1'b1;
        note_lane  = l;
        note_time  = t;
        note_last  = lst;
        tick();
        note_valid = 1'b0;
        if (verbose) begin
            chk("note_req_dropped", 32'(note_req), 32'd0);
            chk("target_led_wait", 32'(target_led), 32'(1) << l);
        end
    endtask

    initial begin
        int sc_m;
        int cb_m;
        int mx_m;
        int extra;
        int k;
        logic [23:0] t;

        vecs[0] = '{3'd2, 24'd100, 1'b0, 1'b0, 24'd50,  1'b1, 24'd102, 3'd2, 2'd2, 300, 1, 1};
        vecs[1] = '{3'd5, 24'd200, 1'b0, 1'b0, 24'd150, 1'b1, 24'd190, 3'd5, 2'd1, 401, 2, 2};
        vecs[2] = '{3'd0, 24'd300, 1'b0, 1'b1, 24'd280, 1'b0, 24'd313, 3'd0, 2'd0, 401, 0, 2};
        vecs[3] = '{3'd6, 24'd500, 1'b0, 1'b0, 24'd450, 1'b1, 24'd516, 3'd6, 2'd0, 401, 0, 2};
        vecs[4] = '{3'd1, 24'd600, 1'b0, 1'b0, 24'd550, 1'b1, 24'd596, 3'd1, 2'd2, 701, 1, 2};
        vecs[5] = '{3'd4, 24'd700, 1'b0, 1'b0, 24'd650, 1'b1, 24'd712, 3'd4, 2'd1, 802, 2, 2};
        vecs[6] = '{3'd6, 24'd800, 1'b0, 1'b0, 24'd750, 1'b1, 24'd805, 3'd6, 2'd1, 904, 3, 3};
        vecs[7] = '{3'd3, 24'd900, 1'b1, 1'b0, 24'd850, 1'b1, 24'd900, 3'd4, 2'd0, 904, 0, 3};

        // Reset state
        tick();
        tick();
        chk("rst_note_req", 32'(note_req), 32'd0);
        chk("rst_note_idx", 32'(note_idx), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Start a song
        en = 1'b1;
        tick();
        chk("start_req", 32'(note_req), 32'd1);

        // Table-driven notes
        for (int i = 0; i < 8; i++) begin
            fetch(vecs[i].lane, vecs[i].ntime, vecs[i].last, i, 1'b1);
            now      = vecs[i].pre_now;
            hit      = vecs[i].pre_hit;
            hit_lane = vecs[i].lane;
            tick();
            hit = 1'b0;
            chk("pre_no_judge", 32'(judge_valid), 32'd0);
            chk("pre_led", 32'(target_led), 32'(1) << vecs[i].lane);
            now      = vecs[i].hit_now;
            hit      = vecs[i].do_hit;
            hit_lane = vecs[i].hlane;
            tick();
            hit = 1'b0;
            chk("judge_valid", 32'(judge_valid), 32'd1);
            chk("judge_grade", 32'(judge_grade), 32'(vecs[i].grade));
            chk("score", 32'(score), 32'(vecs[i].sc));
            chk("combo", 32'(combo), 32'(vecs[i].cb));
            chk("max_combo", 32'(max_combo), 32'(vecs[i].mx));
        end

        // Finish behaviour
        tick();
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_req", 32'(note_req), 32'd0);
        chk("fin_led", 32'(target_led), 32'd0);
        chk("fin_pulse_once", 32'(judge_valid), 32'd0);
        tick();
        chk("fin_hold_done", 32'(done), 32'd1);
        chk("fin_hold_req", 32'(note_req), 32'd0);
        en = 1'b0;
        tick();
        chk("idle_done_kept", 32'(done), 32'd1);
        chk("idle_score_kept", 32'(score), 32'd904);
        chk("idle_max_kept", 32'(max_combo), 32'd3);
        note_valid = 1'b1;
        tick();
        note_valid = 1'b0;
        chk("idle_ignore_valid", 32'(note_req), 32'd0);

        // Wrap: note at 2^24-2, hit at now=2 (delta +4)
        en = 1'b1;
        tick();
        chk("restart_score_clr", 32'(score), 32'd0);
        chk("restart_max_clr", 32'(max_combo), 32'd0);
        chk("restart_done_clr", 32'(done), 32'd0);
        fetch(3'd1, 24'd16777214, 1'b0, 0, 1'b1);
        now = 24'd2;
        hit = 1'b1;
        hit_lane = 3'd1;
        tick();
        hit = 1'b0;
        chk("wrap_grade", 32'(judge_grade), 32'd2);
        chk("wrap_score", 32'(score), 32'd300);
        tick();
        chk("wrap_next_idx", 32'(note_idx), 32'd1);
        en = 1'b0;
        tick();
        chk("abort_req", 32'(note_req), 32'd0);
        chk("abort_score_kept", 32'(score), 32'd300);

        // Second start, abort mid-FETCH
        en = 1'b1;
        tick();
        chk("start2_req", 32'(note_req), 32'd1);
        en = 1'b0;
        tick();
        chk("abort_fetch_req", 32'(note_req), 32'd0);
        chk("abort_fetch_jv", 32'(judge_valid), 32'd0);

        // Abort in WAIT with a perfect hit in the same cycle
        en = 1'b1;
        tick();
        fetch(3'd2, 24'd1000, 1'b0, 0, 1'b1);
        now = 24'd1000;
        hit = 1'b1;
        hit_lane = 3'd2;
        en = 1'b0;
        tick();
        hit = 1'b0;
        chk("abort_wait_jv", 32'(judge_valid), 32'd0);
        chk("abort_wait_score", 32'(score), 32'd0);
        chk("abort_wait_led", 32'(target_led), 32'd0);

        // Saturation of score and combo over a long chart of perfect hits
        en = 1'b1;
        tick();
        sc_m = 0;
        cb_m = 0;
        mx_m = 0;
        extra = 0;
        k = 0;
        t = 24'd5000;
        while (extra < 2 && k < 8000) begin
            fetch(3'd3, t, 1'b0, 0, 1'b0);
            now = t;
            hit = 1'b1;
            hit_lane = 3'd3;
            tick();
            hit = 1'b0;
            sc_m = sc_m + 300 + ((cb_m < 100) ? cb_m : 100);
            if (sc_m > 2097151) sc_m = 2097151;
            if (cb_m < 4095) cb_m = cb_m + 1;
            if (cb_m > mx_m) mx_m = cb_m;
            if (sc_m == 2097151) extra++;
            if (judge_valid !== 1'b1 || 32'(score) !== 32'(sc_m)) begin
                chk("sat_step_score", 32'(score), 32'(sc_m));
            end
            t = t + 24'd100;
            k++;
        end
        chk("sat_score", 32'(score), 32'd2097151);
        chk("sat_model_reached", 32'(sc_m), 32'(score));
        chk("sat_combo", 32'(combo), 32'(cb_m));
        chk("sat_max_combo", 32'(max_combo), 32'(mx_m));

        // Reset mid-WAIT
        fetch(3'd5, t + 24'd1000, 1'b0, 0, 1'b0);
        chk("pre_rst_led", 32'(target_led), 32'h20);
        rst = 1'b1;
        en = 1'b0;
        tick();
        chk("rst_wait_led", 32'(target_led), 32'd0);
        chk("rst_wait_score", 32'(score), 32'd0);
        chk("rst_wait_combo", 32'(combo), 32'd0);
        chk("rst_wait_max", 32'(max_combo), 32'd0);
        chk("rst_wait_grade", 32'(judge_grade), 32'd0);
        chk("rst_wait_idx", 32'(note_idx), 32'd0);
        chk("rst_wait_req", 32'(note_req), 32'd0);
        chk("rst_wait_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
